// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy count and status flags.
// Supports registered read (FWFT=0) or first-word-fall-through (FWFT=1).
module fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [FIFO_WIDTH-1:0]       data_in,
    output logic [FIFO_WIDTH-1:0]       data_out,
    output logic                        wr_ack,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        full,
    output logic                        empty,
    output logic                        almostfull,
    output logic                        almostempty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc;
    logic          rd_acc;

    // Status flags decoded straight from the registered occupancy
    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        almostfull  = (count_q >= AF_C);
        almostempty = (count_q <= AE_C) && (count_q != '0);
    end

    // Request acceptance, next pointers, count and one-cycle event pulses
    always_comb begin
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_acc;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; reset wins over any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; a write during reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : gen_fwft
            // Head entry is visible without a pop; rd_en only advances it
            assign data_out = mem_q[rd_ptr_q];
        end else begin : gen_reg
            logic [FIFO_WIDTH-1:0] dout_q, dout_d;

            // Load the head entry only on an accepted read, else hold
            always_comb begin
                dout_d = dout_q;
                if (rd_acc) begin
                    dout_d = mem_q[rd_ptr_q];
                end
            end

            // Registered read data with a cleared reset value
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: registered-read and FWFT instances.
// Expected data queued on accepted writes, compared when the DUT yields it.
module tb_fifo_param;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, we0, re0;
    logic [W-1:0]  din0, dout0;
    logic          ack0, ovf0, unf0, full0, empty0, af0, ae0;
    logic [CW-1:0] cnt0;

    logic          rst1, we1, re1;
    logic [W-1:0]  din1, dout1;
    logic          ack1, ovf1, unf1, full1, empty1, af1, ae1;
    logic [CW-1:0] cnt1;

    fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst0), .wr_en(we0), .rd_en(re0),
        .data_in(din0), .data_out(dout0), .wr_ack(ack0),
        .overflow(ovf0), .underflow(unf0), .full(full0),
        .empty(empty0), .almostfull(af0), .almostempty(ae0),
        .count(cnt0)
    );

    fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst1), .wr_en(we1), .rd_en(re1),
        .data_in(din1), .data_out(dout1), .wr_ack(ack1),
        .overflow(ovf1), .underflow(unf1), .full(full1),
        .empty(empty1), .almostfull(af1), .almostempty(ae1),
        .count(cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] sb0[$];
    logic [W-1:0] sb1[$];
    int           mc0 = 0;
    int           mc1 = 0;
    logic [W-1:0] exp_dout0 = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock on the registered-read FIFO with full model check
    task automatic cyc0(input logic we, input logic re, input logic [W-1:0] din);
        logic wa, ra, ov, un;
        wa = we && (mc0 != D);
        ra = re && (mc0 != 0);
        ov = we && (mc0 == D);
        un = re && (mc0 == 0);
        we0  = we;
        re0  = re;
        din0 = din;
        @(posedge clk);
        #1;
        we0 = 1'b0;
        re0 = 1'b0;
        if (ra) exp_dout0 = sb0.pop_front();
        if (wa) sb0.push_back(din);
        mc0 = mc0 + (wa ? 1 : 0) - (ra ? 1 : 0);
        chk("wr_ack", ack0, wa);
        chk("overflow", ovf0, ov);
        chk("underflow", unf0, un);
        chk("count", cnt0, mc0);
        chk("full", full0, mc0 == D);
        chk("empty", empty0, mc0 == 0);
        chk("almostfull", af0, mc0 >= D - 1);
        chk("almostempty", ae0, (mc0 <= 1) && (mc0 != 0));
        chk("data_out", dout0, exp_dout0);
    endtask

    // One clock on the FWFT FIFO; head must be visible while non-empty
    task automatic cyc1(input logic we, input logic re, input logic [W-1:0] din);
        logic wa, ra;
        wa = we && (mc1 != D);
        ra = re && (mc1 != 0);
        we1  = we;
        re1  = re;
        din1 = din;
        @(posedge clk);
        #1;
        we1 = 1'b0;
        re1 = 1'b0;
        if (ra) void'(sb1.pop_front());
        if (wa) sb1.push_back(din);
        mc1 = mc1 + (wa ? 1 : 0) - (ra ? 1 : 0);
        chk("fwft_wr_ack", ack1, wa);
        chk("fwft_count", cnt1, mc1);
        chk("fwft_empty", empty1, mc1 == 0);
        if (mc1 != 0) chk("fwft_data_out", dout1, sb1[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; we0 = 1'b0; re0 = 1'b0; din0 = '0;
        rst1 = 1'b1; we1 = 1'b0; re1 = 1'b0; din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        chk("rst_count", cnt0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_flags", {ack0, ovf0, unf0}, 0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) cyc0(1'b1, 1'b0, W'(i));
        cyc0(1'b1, 1'b0, 16'h0009);
        for (int i = 0; i < 8; i++) cyc0(1'b0, 1'b1, '0);

        // Underflow, then simultaneous requests while empty
        cyc0(1'b0, 1'b1, '0);
        cyc0(1'b1, 1'b1, 16'h0055);
        cyc0(1'b0, 1'b1, '0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < 5; i++) cyc0(1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) cyc0(1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < 6; i++) cyc0(1'b0, 1'b1, '0);

        // Simultaneous requests at mid occupancy
        for (int i = 0; i < 3; i++) cyc0(1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < 6; i++) cyc0(1'b1, 1'b1, W'($urandom));
        for (int i = 0; i < 3; i++) cyc0(1'b0, 1'b1, '0);

        // Simultaneous requests while full
        for (int i = 0; i < 8; i++) cyc0(1'b1, 1'b0, W'($urandom));
        cyc0(1'b1, 1'b1, 16'hDEAD);
        for (int i = 0; i < 7; i++) cyc0(1'b0, 1'b1, '0);

        // Random traffic
        for (int i = 0; i < 60; i++)
            cyc0(1'($urandom), 1'($urandom), W'($urandom));
        while (mc0 != 0) cyc0(1'b0, 1'b1, '0);

        // Reset with count=6 and a write in the reset cycle
        for (int i = 0; i < 6; i++) cyc0(1'b1, 1'b0, W'(16'h0100 + i));
        rst0 = 1'b1;
        we0  = 1'b1;
        din0 = 16'hBEEF;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        we0  = 1'b0;
        sb0.delete();
        mc0 = 0;
        exp_dout0 = '0;
        chk("rst6_count", cnt0, 0);
        chk("rst6_empty", empty0, 1);
        chk("rst6_full", full0, 0);
        chk("rst6_ae", ae0, 0);
        chk("rst6_af", af0, 0);
        chk("rst6_flags", {ack0, ovf0, unf0}, 0);
        chk("rst6_dout", dout0, 0);
        cyc0(1'b0, 1'b1, '0);
        cyc0(1'b1, 1'b0, 16'h1234);
        cyc0(1'b0, 1'b1, '0);

        // FWFT: zero-latency head, rd_en pops
        cyc1(1'b1, 1'b0, 16'hABCD);
        cyc1(1'b0, 1'b0, '0);
        cyc1(1'b0, 1'b1, '0);
        chk("fwft_empty_after_pop", empty1, 1);
        for (int i = 0; i < 3; i++) cyc1(1'b1, 1'b0, W'(16'h0A00 + i));
        cyc1(1'b1, 1'b1, 16'h0B00);
        for (int i = 0; i < 12; i++) cyc1(1'b1, 1'b0, W'($urandom));
        chk("fwft_full", full1, 1);
        while (mc1 != 0) cyc1(1'b0, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
